// File: rtl/key_schedule.sv
// key_schedule
//   Expands a 64-bit cipher key into round keys 0..NUM_ROUNDS and streams
//   them one per cycle over a valid/ready handshake to the round stage.
//   Round key 0 is the cipher key itself; each later key is derived from the
//   previous one with a nibble S-box, a rotate and a round constant.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request to expand cipherKey (only looked at while idle)
//   cipherKey  64-bit key, captured when start is accepted
//   roundKey   current round key
//   roundIdx   index of the key on roundKey (0..NUM_ROUNDS)
//   keyValid   roundKey/roundIdx are valid
//   keyReady   downstream accepts roundKey this cycle
//   busy       expansion in progress (EMIT or DONE)
//   done       one-cycle pulse after the last key has been taken
module key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] cipherKey,
  output logic [63:0] roundKey,
  output logic [3:0]  roundIdx,
  output logic        keyValid,
  input  logic        keyReady,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [3:0]  idx_q, idx_d;
  // Cleared by reset and set by the first clock edge after release, so a
  // start that lines up with reset deassertion is never taken.
  logic        arm_q, arm_d;

  logic [63:0] next_key;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      default: r = 4'h2;
    endcase
    return r;
  endfunction

  // Round constant for the key being produced; index 0 and anything past 10
  // are never used for a real key and return zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:  r = 8'h01;
      4'd2:  r = 8'h02;
      4'd3:  r = 8'h04;
      4'd4:  r = 8'h08;
      4'd5:  r = 8'h10;
      4'd6:  r = 8'h20;
      4'd7:  r = 8'h40;
      4'd8:  r = 8'h80;
      4'd9:  r = 8'h1B;
      4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Next round key straight from the registered key, no pipelining, so a
  // transfer can load the following key on the same edge.
  always_comb begin
    logic [15:0] rot;
    logic [15:0] t;
    logic [15:0] w0n, w1n, w2n, w3n;
    rot = {key_q[11:0], key_q[15:12]};
    t = '0;
    for (int n = 0; n < 4; n++) begin
      t[4*n +: 4] = sbox(rot[4*n +: 4]);
    end
    t[15:8] = t[15:8] ^ rcon(idx_q + 4'd1);
    w0n = key_q[63:48] ^ t;
    w1n = key_q[47:32] ^ w0n;
    w2n = key_q[31:16] ^ w1n;
    w3n = key_q[15:0]  ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  // Next-state logic. The key register only moves on an accepted start or
  // on a handshake, which keeps roundKey/roundIdx frozen under back-pressure.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    arm_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (start && arm_q) begin
          key_d   = cipherKey;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (keyReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      arm_q   <= arm_d;
    end
  end

  assign roundKey = key_q;
  assign roundIdx = idx_q;
  assign keyValid = (state_q == EMIT);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
